// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive deframer.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;
  localparam logic [47:0] ETH_BCAST    = 48'hFFFFFFFFFFFF;

  // One byte of reflected CRC-32, LSB of the byte first as on the wire.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Registered byte-wise CRC-32 accumulator (reflected, no final inversion).
module eth_crc32 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  import eth_rx_pkg::*;

  logic [31:0] r_crc;

  // Accumulate one byte per enabled cycle; clear restarts from the seed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_crc <= CRC_INIT;
    end else if (clear_i) begin
      r_crc <= CRC_INIT;
    end else if (en_i) begin
      r_crc <= crc32_byte(r_crc, data_i);
    end
  end

  assign crc_o = r_crc;

endmodule

// File: rtl/eth_rx_frame_deframer.sv
// GMII receive deframer: strips preamble/SFD, checks and removes FCS,
// emits frame bytes as a push-only byte stream with a per-frame bad flag.
// Optional destination address filter: define ETH_RX_MAC_FILTER_EN.
//
// state    | meaning
// IDLE     | waiting for dv, no frame in progress
// PREAMBLE | receiving 0x55 bytes, waiting for SFD
// DATA     | frame body: CRC, delay line, length, error sticky
// DROP     | discarding bytes until dv falls
module eth_rx_frame_deframer #(
  parameter int MAX_LEN = 1522,
  parameter int MIN_LEN = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  gmii_rxd_i,
  input  logic        gmii_rx_dv_i,
  input  logic        gmii_rx_er_i,
  input  logic [47:0] mac_addr_i,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  output logic        m_axis_tlast_o,
  output logic        m_axis_tuser_o,
  output logic        frame_ok_o,
  output logic        frame_err_o
);
  import eth_rx_pkg::*;

  localparam logic [10:0] LP_MAX_LEN = 11'(MAX_LEN);
  localparam logic [10:0] LP_MIN_LEN = 11'(MIN_LEN);
  localparam logic [10:0] LP_LEN_SAT = 11'h7FF;

  rx_state_e       r_state;
  rx_state_e       w_state_nxt;
  logic            w_sof;
  logic            w_shift;
  logic            w_close;
  logic            w_reject;
  logic            w_short;
  logic            w_bad;
  logic [31:0]     w_crc;

  // r_dly[0] is the newest byte, r_dly[3] the oldest.
  logic [3:0][7:0] r_dly;
  logic [7:0]      r_pend;
  logic            r_pend_vld;
  logic [10:0]     r_len;
  logic            r_sticky;

  logic [7:0]      r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic            r_tuser;
  logic            r_ok;
  logic            r_err;

`ifdef ETH_RX_MAC_FILTER_EN
  // At byte 5 the pending register holds DA byte 0 and the delay line bytes 1..4.
  logic [47:0] w_da;
  logic        w_da_match;
  assign w_da       = {r_pend, r_dly[3], r_dly[2], r_dly[1], r_dly[0], gmii_rxd_i};
  assign w_da_match = (w_da == mac_addr_i) || (w_da == ETH_BCAST) || r_pend[0];
  assign w_reject   = (r_len == 11'd5) && !w_da_match;
  assign w_short    = (r_len < 11'd6);
`else
  logic w_unused_mac;
  assign w_unused_mac = ^mac_addr_i;
  assign w_reject     = 1'b0;
  assign w_short      = 1'b0;
`endif

  eth_crc32 u_crc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (w_sof),
    .en_i    (w_shift),
    .data_i  (gmii_rxd_i),
    .crc_o   (w_crc)
  );

  assign w_bad = (w_crc != CRC_RESIDUE) || r_sticky ||
                 (r_len < LP_MIN_LEN) || (r_len > LP_MAX_LEN);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_sof       = 1'b0;
    w_shift     = 1'b0;
    w_close     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (gmii_rx_dv_i) begin
          w_state_nxt = (gmii_rxd_i == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_dv_i) begin
          w_state_nxt = ST_IDLE;
        end else if (gmii_rxd_i == ETH_SFD) begin
          w_state_nxt = ST_DATA;
          w_sof       = 1'b1;
        end else if (gmii_rxd_i != ETH_PREAMBLE) begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!gmii_rx_dv_i) begin
          w_state_nxt = ST_IDLE;
          w_close     = 1'b1;
        end else if (w_reject) begin
          w_state_nxt = ST_DROP;
        end else begin
          w_shift = 1'b1;
        end
      end
      ST_DROP: begin
        if (!gmii_rx_dv_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Delay line, pending byte, length, error sticky and registered stream outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dly      <= '0;
      r_pend     <= 8'h00;
      r_pend_vld <= 1'b0;
      r_len      <= 11'd0;
      r_sticky   <= 1'b0;
      r_tdata    <= 8'h00;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
      if (w_sof) begin
        r_len      <= 11'd0;
        r_sticky   <= 1'b0;
        r_pend_vld <= 1'b0;
      end
      if (w_shift) begin
        r_dly <= {r_dly[2:0], gmii_rxd_i};
        if (r_len != LP_LEN_SAT) begin
          r_len <= r_len + 11'd1;
        end
        if (gmii_rx_er_i) begin
          r_sticky <= 1'b1;
        end
        if (r_len >= 11'd4) begin
          r_pend     <= r_dly[3];
          r_pend_vld <= 1'b1;
        end
        if (r_pend_vld) begin
          r_tvalid <= 1'b1;
          r_tdata  <= r_pend;
        end
      end
      if (w_close) begin
        r_pend_vld <= 1'b0;
        if (r_pend_vld && !w_short) begin
          r_tvalid <= 1'b1;
          r_tlast  <= 1'b1;
          r_tdata  <= r_pend;
          r_tuser  <= w_bad;
          r_ok     <= !w_bad;
          r_err    <= w_bad;
        end
      end
    end
  end

  assign m_axis_tdata_o  = r_tdata;
  assign m_axis_tvalid_o = r_tvalid;
  assign m_axis_tlast_o  = r_tlast;
  assign m_axis_tuser_o  = r_tuser;
  assign frame_ok_o      = r_ok;
  assign frame_err_o     = r_err;

endmodule

// File: tb/tb_eth_rx_frame_deframer.sv
// Scoreboard bench for eth_rx_frame_deframer: expected beats are queued as
// bytes are driven and compared as the stream comes out.
module tb_eth_rx_frame_deframer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  gmii_rxd_i;
  logic        gmii_rx_dv_i;
  logic        gmii_rx_er_i;
  logic [47:0] mac_addr_i;
  logic [7:0]  m_axis_tdata_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tlast_o;
  logic        m_axis_tuser_o;
  logic        frame_ok_o;
  logic        frame_err_o;

  eth_rx_frame_deframer dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .gmii_rxd_i      (gmii_rxd_i),
    .gmii_rx_dv_i    (gmii_rx_dv_i),
    .gmii_rx_er_i    (gmii_rx_er_i),
    .mac_addr_i      (mac_addr_i),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tuser_o  (m_axis_tuser_o),
    .frame_ok_o      (frame_ok_o),
    .frame_err_o     (frame_err_o)
  );

  always #4 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t      sb_q[$];
  logic [7:0] tx[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_beats = 0;
  int n_ok = 0;
  int n_errp = 0;
  int t_beat0 = 0;
  int t_last = 0;
  bit seen_beat0 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Stream monitor: every beat must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (m_axis_tvalid_o) begin
        beat_t e;
        n_beats++;
        if (!seen_beat0) begin
          seen_beat0 = 1'b1;
          t_beat0    = cyc;
        end
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 32'(m_axis_tdata_o), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("tdata", 32'(m_axis_tdata_o), 32'(e.d));
          chk("tlast", 32'(m_axis_tlast_o), 32'(e.l));
          chk("tuser", 32'(m_axis_tuser_o), 32'(e.u));
          chk("frame_ok", 32'(frame_ok_o), 32'(e.l & ~e.u));
          chk("frame_err", 32'(frame_err_o), 32'(e.l & e.u));
          if (m_axis_tlast_o) t_last = cyc;
        end
      end else if (frame_ok_o || frame_err_o) begin
        chk("pulse_without_beat", 32'(frame_ok_o | frame_err_o), 32'd0);
      end
      if (frame_ok_o)  n_ok++;
      if (frame_err_o) n_errp++;
    end
  end

  function automatic bit da_pass();
`ifdef ETH_RX_MAC_FILTER_EN
    logic [47:0] da;
    if (tx.size() < 6) return 1'b0;
    da = {tx[0], tx[1], tx[2], tx[3], tx[4], tx[5]};
    return (da == mac_addr_i) || (da == 48'hFFFFFFFFFFFF) || tx[0][0];
`else
    return 1'b1;
`endif
  endfunction

  task automatic build(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(i[7:0]);
  endtask

  task automatic set_da(input logic [47:0] da);
    for (int k = 0; k < 6; k++) tx[k] = da[47-8*k -: 8];
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic dv);
    @(posedge clk_i);
    #1;
    gmii_rx_dv_i = dv;
    gmii_rxd_i   = b;
    gmii_rx_er_i = 1'b0;
  endtask

  // Sends tx[] with a computed FCS; beat k is queued when byte k+5 is driven.
  task automatic send_frame(input int pre_n, input int er_idx, input bit bad_fcs, input int abort_at);
    logic [7:0]  fr[$];
    logic [31:0] c;
    int          n;
    bit          exp_user;
    bit          pass;
    int          t_first;
    int          t_dv0;
    fr = tx;
    c  = 32'hFFFFFFFF;
    foreach (tx[i]) begin
      c = c ^ {24'd0, tx[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
    n = fr.size();
    if (bad_fcs) fr[n-1] = ~fr[n-1];
    exp_user = bad_fcs || (er_idx >= 0 && er_idx < n) || (n < 64) || (n > 1522);
    pass     = da_pass();
    t_first  = 0;
    seen_beat0 = 1'b0;
    t_last     = -100;
    for (int i = 0; i < pre_n; i++) drive_byte(8'h55, 1'b1);
    drive_byte(8'hD5, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        drive_byte(fr[i], 1'b1);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid_o), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata_o), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast_o), 32'd0);
        chk("rst_pulses", 32'(frame_ok_o | frame_err_o | m_axis_tuser_o), 32'd0);
        chk("rst_sb_empty", 32'(sb_q.size()), 32'd0);
        gmii_rx_dv_i = 1'b0;
        gmii_rxd_i   = 8'h00;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        return;
      end
      drive_byte(fr[i], 1'b1);
      gmii_rx_er_i = (i == er_idx);
      if (i == 0) t_first = cyc;
      if (pass && i >= 5) sb_q.push_back('{d: fr[i-5], l: 1'b0, u: 1'b0});
    end
    drive_byte(8'h00, 1'b0);
    t_dv0 = cyc;
    if (pass && n >= 5) sb_q.push_back('{d: fr[n-5], l: 1'b1, u: exp_user});
    repeat (11) @(posedge clk_i);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    if (pass && n >= 10) begin
      chk("first_beat_lat", 32'(t_beat0 - t_first), 32'd6);
      chk("tlast_lat", 32'(t_last - t_dv0), 32'd1);
    end
  endtask

  initial begin
    int nb;
    int nok;
    int nerr;
    rst_ni       = 1'b0;
    gmii_rxd_i   = 8'h00;
    gmii_rx_dv_i = 1'b0;
    gmii_rx_er_i = 1'b0;
    mac_addr_i   = 48'h020000000001;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_tvalid", 32'(m_axis_tvalid_o), 32'd0);
    chk("reset_tdata", 32'(m_axis_tdata_o), 32'd0);
    chk("reset_tlast", 32'(m_axis_tlast_o), 32'd0);
    chk("reset_tuser", 32'(m_axis_tuser_o), 32'd0);
    chk("reset_ok", 32'(frame_ok_o), 32'd0);
    chk("reset_err", 32'(frame_err_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    // Good 64-byte frame.
    nok = n_ok; nerr = n_errp; nb = n_beats;
    build(60);
    send_frame(7, -1, 1'b0, -1);
    chk("good_beats", 32'(n_beats - nb), 32'd60);
    chk("good_ok_pulse", 32'(n_ok - nok), 32'd1);
    chk("good_err_pulse", 32'(n_errp - nerr), 32'd0);

    // Corrupted FCS.
    nerr = n_errp;
    send_frame(7, -1, 1'b1, -1);
    chk("badfcs_err_pulse", 32'(n_errp - nerr), 32'd1);

    // rx_er on data byte 20.
    send_frame(7, 20, 1'b0, -1);

    // Runt: 40-byte payload plus FCS.
    build(40);
    send_frame(7, -1, 1'b0, -1);

    // Oversize: 1600 bytes including FCS.
    build(1596);
    send_frame(7, -1, 1'b0, -1);

    // Aborted preamble and bad preamble byte.
    nb = n_beats; nok = n_ok + n_errp;
    repeat (3) drive_byte(8'h55, 1'b1);
    drive_byte(8'h00, 1'b0);
    repeat (12) @(posedge clk_i);
    drive_byte(8'h55, 1'b1);
    drive_byte(8'h55, 1'b1);
    drive_byte(8'h57, 1'b1);
    repeat (4) drive_byte(8'h55, 1'b1);
    drive_byte(8'hD5, 1'b1);
    for (int i = 0; i < 64; i++) drive_byte(i[7:0], 1'b1);
    drive_byte(8'h00, 1'b0);
    repeat (12) @(posedge clk_i);
    chk("drop_beats", 32'(n_beats - nb), 32'd0);
    chk("drop_pulses", 32'(n_ok + n_errp - nok), 32'd0);

    // Three good frames at minimum IPG.
    nok = n_ok;
    build(60);
    for (int f = 0; f < 3; f++) begin
      for (int i = 6; i < 60; i++) tx[i] = 8'(i + 17 * f);
      send_frame(7, -1, 1'b0, -1);
    end
    chk("ipg_ok_pulses", 32'(n_ok - nok), 32'd3);

    // Reset at data byte 30, then a clean frame.
    build(60);
    send_frame(7, -1, 1'b0, 30);
    nok = n_ok; nerr = n_errp;
    send_frame(7, -1, 1'b0, -1);
    chk("post_rst_ok", 32'(n_ok - nok), 32'd1);
    chk("post_rst_err", 32'(n_errp - nerr), 32'd0);

`ifdef ETH_RX_MAC_FILTER_EN
    nok = n_ok;
    build(60);
    set_da(48'h020000000001);
    send_frame(7, -1, 1'b0, -1);
    set_da(48'hFFFFFFFFFFFF);
    send_frame(7, -1, 1'b0, -1);
    chk("filt_pass_ok", 32'(n_ok - nok), 32'd2);
    nb = n_beats; nok = n_ok + n_errp;
    set_da(48'h020000000002);
    send_frame(7, -1, 1'b0, -1);
    chk("filt_rej_beats", 32'(n_beats - nb), 32'd0);
    chk("filt_rej_pulses", 32'(n_ok + n_errp - nok), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_rx_frame_deframer.md
# eth_rx_frame_deframer

Receive-path stage between the RGMII receiver's GMII byte output and the receive buffer behind the AXI slave of `eth_rgmii`. Strips preamble/SFD, checks FCS (CRC-32), removes the 4 FCS bytes and emits the frame as a byte-wide AXI4-Stream with per-frame error flag. Push-only: the consumer, an RX FIFO, must always accept.

## Interface
Parameters:
- `MAX_LEN`, 1522: largest legal frame length in bytes, DA through FCS inclusive.
- `MIN_LEN`, 64: smallest legal frame length in bytes, DA through FCS inclusive.

Ports:
- `clk_i` in 1: GMII receive byte clock (125 MHz); one clock, no other domain.
- `rst_ni` in 1: asynchronous, active-low reset.
- `gmii_rxd_i` in 8: received byte.
- `gmii_rx_dv_i` in 1: data valid.
- `gmii_rx_er_i` in 1: receive error.
- `mac_addr_i` in 48: station address; byte 0 is the first received DA byte. Ignored when filtering is compiled out.
- `m_axis_tdata_o` out 8: frame byte.
- `m_axis_tvalid_o` out 1: byte valid; no tready, and every beat is consumed.
- `m_axis_tlast_o` out 1: last payload byte of the frame.
- `m_axis_tuser_o` out 1: bad frame; valid only with tlast.
- `frame_ok_o` out 1: one-cycle pulse, frame delivered good.
- `frame_err_o` out 1: one-cycle pulse, frame delivered with tuser=1.

## Operation
State machine states: IDLE, PREAMBLE, DATA, DROP.

Transitions:
- IDLE → PREAMBLE on dv=1 with rxd=0x55.
- IDLE → DROP on dv=1 with any other byte.
- PREAMBLE: 0x55 stays in PREAMBLE; 0xD5 (SFD) goes to DATA; any other byte goes to DROP.
- PREAMBLE → IDLE on dv=0, silently.
- DROP → IDLE on dv=0.
- DATA → IDLE on dv=0, after the close action below.

DATA path:
- Every byte feeds the CRC-32 engine: reflected poly 0xEDB88320, init 0xFFFFFFFF. The CRC resets on SFD.
- Bytes pass through a 4-byte delay line, which holds the FCS at the end of the frame.
- A byte leaving the delay line goes into a 1-byte pending register. The previous pending byte is emitted with tlast=0.
- Length counter: 11 bits, saturates at 2047, counts DA..FCS.
- Error sticky bit is set by rx_er=1 on any DATA byte.

Close, on dv=0 in DATA:
- If the pending register holds a byte, emit it with tlast=1.
- tuser=1 if any of: CRC register ≠ 0xDEBB20E3 residue, error sticky, length < MIN_LEN, length > MAX_LEN.
- Pulse `frame_ok_o` or `frame_err_o` in the same cycle as the tlast beat.

Boundary cases:
- Frame with ≤4 DATA bytes: no beats, no pulse.
- dv=0 while in PREAMBLE: no output.
- Reset mid-frame: all state clears immediately. A partial frame never receives tlast; the consumer resets together with this block.

## Timing
- All outputs registered.
- Reset values: tdata 0x00; tvalid, tlast, tuser, frame_ok_o, frame_err_o all 0; state IDLE; CRC 0xFFFFFFFF; length 0; sticky 0.
- Data byte k (k=0 is the first DA byte) is emitted as tvalid in the cycle after byte k+5 is sampled.
- The tlast beat appears in the cycle after dv is sampled 0.
- The tlast beat is never adjacent to the next frame's first beat: the GMII inter-frame gap plus 8 preamble bytes exceeds the pipeline depth.
- Back-to-back frames separated by the minimum 12-byte IPG are handled without loss.
- tvalid may gap only when dv gaps; dv is contiguous per GMII.

## Configuration
`ETH_RX_MAC_FILTER_EN`:
- Defined: the DA (first 6 DATA bytes) is compared to `mac_addr_i`, to broadcast FF:FF:FF:FF:FF:FF, and to multicast (DA byte 0 bit 0 = 1).
- The decision is made combinationally in the cycle byte 5 is sampled, from bytes 0–4 held plus the incoming byte. No beat is emitted before the decision.
- A rejected frame enters DROP: no beats, no pulses.
- A frame shorter than 6 DATA bytes is dropped.
- Undefined: promiscuous; `mac_addr_i` is unused.

## Structure
- Package `eth_rx_pkg`:
  - state enum;
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3, ETH_BCAST=48'hFFFFFFFFFFFF.
- Sub-module `eth_crc32`:
  - ports: clk_i, rst_ni, clear_i, en_i, data_i[7:0], crc_o[31:0];
  - a registered byte-wise update.

## Test plan
- 7×0x55, 0xD5, then a 60-byte payload 0x00..0x3B with correct FCS → 60 beats 0x00..0x3B; tlast on 0x3B, tuser=0; frame_ok_o pulse; first beat 6 cycles after the first DA byte is sampled.
- Same frame with FCS last byte inverted → 60 beats; tuser=1; frame_err_o pulse.
- Same frame with rx_er=1 on data byte 20 → tuser=1.
- 40-byte payload with valid FCS → 40 beats; tuser=1 (runt).
- 1600-byte frame → tuser=1 (oversize).
- dv dropped after 3 preamble bytes, or preamble byte 0x57 → no beats.
- Three good frames at 12-byte IPG → 3 complete streams, 3 ok pulses.
- Reset asserted at data byte 30 → outputs 0 asynchronously; the next frame is received clean.
- With `ETH_RX_MAC_FILTER_EN`, `mac_addr_i`=02:00:00:00:00:01:
  - DA 02:00:00:00:00:01 → passed;
  - DA FF:FF:FF:FF:FF:FF → passed;
  - DA 02:00:00:00:00:02 → no beats, no pulses.
